// File: rtl/pudiannao_pkg.sv
// Shared constants for the output-selection scheduler.
//   - requester indices and count
//   - selector codes driven to the output mux
//   - default output lane count (N_LANES), used as the LANES parameter default
//   - FSM state type and small index/code helpers
package pudiannao_pkg;

  localparam int N_REQ   = 6;
  localparam int IDX_W   = 3;
  localparam int SEL_W   = 3;
  localparam int N_LANES = 16;

  localparam logic [IDX_W-1:0] REQ_COUNTER = 3'd0;
  localparam logic [IDX_W-1:0] REQ_ADDER   = 3'd1;
  localparam logic [IDX_W-1:0] REQ_MULT    = 3'd2;
  localparam logic [IDX_W-1:0] REQ_ACC     = 3'd3;
  localparam logic [IDX_W-1:0] REQ_NONLIN  = 3'd4;
  localparam logic [IDX_W-1:0] REQ_KSORT   = 3'd5;

  localparam logic [SEL_W-1:0] SEL_IDLE    = 3'b000;
  localparam logic [SEL_W-1:0] SEL_COUNTER = 3'b001;
  localparam logic [SEL_W-1:0] SEL_ADDER   = 3'b010;
  localparam logic [SEL_W-1:0] SEL_MULT    = 3'b011;
  localparam logic [SEL_W-1:0] SEL_ACC     = 3'b100;
  localparam logic [SEL_W-1:0] SEL_NONLIN  = 3'b101;
  localparam logic [SEL_W-1:0] SEL_KSORT   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  // Selector codes are the requester index plus one; zero is reserved for idle.
  function automatic logic [SEL_W-1:0] sel_code(logic [IDX_W-1:0] idx);
    return SEL_W'(idx + 3'd1);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/out_sel_sched_rr_arbiter.sv
// 6-way round-robin arbiter (purely combinational).
//   req_i    : pending requests
//   last_i   : index of the most recently served requester
//   winner_o : one-hot winner, searched from (last_i+1) mod 6 upward; zero if no request
module rr_arbiter
  import pudiannao_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] winner_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    cand     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((int'(last_i) + off) % N_REQ);
      if (!found && req_i[cand]) begin
        winner_o[cand] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_sel_sched.sv
// Output selection scheduler: picks one result-ready requester round-robin,
// steers the output mux (sel/count), and presents its beats to a
// valid/ready downstream, pulsing gnt to the requester after the final beat.
//   clk, rst (async, active low)
//   req       : result-ready requests, [5] is the multi-beat k-sort
//   gnt       : one-cycle one-hot acknowledge after the last beat is accepted
//   sel/count : mux selector and k-sort beat index
//   out_valid/out_ready/out_last/lane_mask : beat handshake and qualifiers
//   busy      : high whenever the FSM is not idle
module out_sel_sched
  import pudiannao_pkg::*;
#(
  parameter int K     = 20,
  parameter int LANES = N_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [31:0]        count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [LANES-1:0]   lane_mask,
  output logic               busy
);

  localparam int               KS_BEATS     = (K + LANES - 1) / LANES;
  localparam int               KS_LAST_N    = K - LANES * (KS_BEATS - 1);
  localparam logic [LANES-1:0] KS_LAST_MASK = {LANES{1'b1}} >> (LANES - KS_LAST_N);
  localparam logic [31:0]      KS_LAST_CNT  = 32'(KS_BEATS - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [31:0]        count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [LANES-1:0]   lane_mask_q, lane_mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [N_REQ-1:0]   winner;
  logic [IDX_W-1:0]   win_idx;
  logic               final_beat;

  rr_arbiter u_arb (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner)
  );

  assign win_idx = onehot_to_idx(winner);

  function automatic logic is_final(logic [IDX_W-1:0] idx, logic [31:0] cnt);
    return (idx != REQ_KSORT) || (cnt == KS_LAST_CNT);
  endfunction

  // Scalar results only occupy lane 0; the last k-sort beat is partially filled.
  function automatic logic [LANES-1:0] beat_mask(logic [IDX_W-1:0] idx, logic [31:0] cnt);
    if (idx == REQ_ACC || idx == REQ_NONLIN) return LANES'(1);
    if (idx == REQ_KSORT && cnt == KS_LAST_CNT) return KS_LAST_MASK;
    return {LANES{1'b1}};
  endfunction

  assign final_beat = is_final(idx_q, count_q);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      sel_q       <= SEL_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      lane_mask_q <= '0;
      idx_q       <= '0;
      last_q      <= REQ_KSORT;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      lane_mask_q <= lane_mask_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|req) state_d = S_SETUP;
      S_SETUP: state_d = S_XFER;
      S_XFER:  if (out_ready) state_d = final_beat ? S_IDLE : S_SETUP;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    gnt_d       = '0;
    sel_d       = sel_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    lane_mask_d = lane_mask_q;
    idx_d       = idx_q;
    last_d      = last_q;
    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (|req) begin
          idx_d       = win_idx;
          sel_d       = sel_code(win_idx);
          lane_mask_d = beat_mask(win_idx, 32'd0);
        end else begin
          sel_d       = SEL_IDLE;
          lane_mask_d = '0;
        end
      end
      S_SETUP: begin
        out_valid_d = 1'b1;
        out_last_d  = final_beat;
      end
      S_XFER: begin
        if (out_ready) begin
          if (final_beat) begin
            gnt_d       = N_REQ'(1) << idx_q;
            last_d      = idx_q;
            sel_d       = SEL_IDLE;
            count_d     = '0;
            lane_mask_d = '0;
          end else begin
            count_d     = count_q + 32'd1;
            lane_mask_d = beat_mask(idx_q, count_q + 32'd1);
          end
        end else begin
          out_valid_d = 1'b1;
          out_last_d  = out_last_q;
        end
      end
      default: begin
        sel_d       = SEL_IDLE;
        count_d     = '0;
        lane_mask_d = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign count     = count_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign lane_mask = lane_mask_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_out_sel_sched.sv
module tb_out_sel_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  req = '0;
  logic [5:0]  gnt;
  logic [2:0]  sel;
  logic [31:0] count;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [15:0] lane_mask;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  out_sel_sched #(.K(20), .LANES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .lane_mask (lane_mask),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    out_ready = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Waits up to max_cycles for a nonzero gnt; returns it (zero on timeout).
  task automatic wait_gnt(input int max_cycles, output logic [5:0] g);
    g = '0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      if (gnt !== 6'b0) begin
        g = gnt;
        $display("txn: gnt=%b at cycle %0d of wait", gnt, c);
        return;
      end
    end
  endtask

  task automatic test_reset();
    req = '0; out_ready = 1'b0; rst = 1'b0;
    #3;
    checks++;
    if ({gnt, sel, count, out_valid, out_last, lane_mask, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b sel=%b count=%0d valid=%b last=%b mask=%h busy=%b, required all zero",
               gnt, sel, count, out_valid, out_last, lane_mask, busy);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || sel !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle: busy=%b sel=%b, required busy=0 sel=000", busy, sel);
    end
    $display("txn: reset done");
  endtask

  task automatic test_counter();
    do_reset();
    req = 6'b000001; out_ready = 1'b1;
    tick();                                   // cycle 1: SETUP
    req = '0;
    checks++;
    if (sel !== 3'b001 || out_valid !== 1'b0 || busy !== 1'b1 || count !== 32'd0) begin
      failures++;
      $display("FAIL counter_setup: sel=%b valid=%b busy=%b count=%0d, required sel=001 valid=0 busy=1 count=0",
               sel, out_valid, busy, count);
    end
    tick();                                   // cycle 2: XFER
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || lane_mask !== 16'hFFFF || sel !== 3'b001 || gnt !== 6'b0) begin
      failures++;
      $display("FAIL counter_xfer: valid=%b last=%b mask=%h sel=%b gnt=%b, required 1 1 ffff 001 000000",
               out_valid, out_last, lane_mask, sel, gnt);
    end
    tick();                                   // cycle 3: gnt pulse
    checks++;
    if (gnt !== 6'b000001 || out_valid !== 1'b0 || sel !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL counter_gnt: gnt=%b valid=%b sel=%b busy=%b, required 000001 0 000 0",
               gnt, out_valid, sel, busy);
    end
    $display("txn: counter gnt=%b", gnt);
    tick();
    checks++;
    if (gnt !== 6'b0) begin
      failures++;
      $display("FAIL counter_gnt_pulse: gnt=%b, required 000000", gnt);
    end
  endtask

  task automatic test_ksort();
    do_reset();
    req = 6'b100000; out_ready = 1'b1;
    tick();                                   // SETUP beat0
    req = '0;
    checks++;
    if (sel !== 3'b110 || count !== 32'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ksort_setup0: sel=%b count=%0d valid=%b, required 110 0 0", sel, count, out_valid);
    end
    tick();                                   // XFER beat0
    checks++;
    if (out_valid !== 1'b1 || count !== 32'd0 || lane_mask !== 16'hFFFF || out_last !== 1'b0) begin
      failures++;
      $display("FAIL ksort_beat0: valid=%b count=%0d mask=%h last=%b, required 1 0 ffff 0",
               out_valid, count, lane_mask, out_last);
    end
    tick();                                   // SETUP beat1
    checks++;
    if (out_valid !== 1'b0 || count !== 32'd1 || gnt !== 6'b0 || sel !== 3'b110) begin
      failures++;
      $display("FAIL ksort_setup1: valid=%b count=%0d gnt=%b sel=%b, required 0 1 000000 110",
               out_valid, count, gnt, sel);
    end
    tick();                                   // XFER beat1
    checks++;
    if (out_valid !== 1'b1 || count !== 32'd1 || lane_mask !== 16'h000F || out_last !== 1'b1) begin
      failures++;
      $display("FAIL ksort_beat1: valid=%b count=%0d mask=%h last=%b, required 1 1 000f 1",
               out_valid, count, lane_mask, out_last);
    end
    tick();
    checks++;
    if (gnt !== 6'b100000 || count !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ksort_gnt: gnt=%b count=%0d busy=%b, required 100000 0 0", gnt, count, busy);
    end
    $display("txn: ksort gnt=%b", gnt);
    tick();
    checks++;
    if (gnt !== 6'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ksort_single_gnt: gnt=%b busy=%b, required 000000 0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] g;
    int order [7] = '{0, 1, 2, 3, 4, 5, 0};
    do_reset();
    req = 6'b111111; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_gnt(12, g);
      checks++;
      if (g !== (6'b1 << order[i])) begin
        failures++;
        $display("FAIL rr_order[%0d]: gnt=%b, required %b", i, g, 6'b1 << order[i]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] g;
    logic [5:0] exp_g [3] = '{6'b000010, 6'b000100, 6'b000010};
    do_reset();
    req = 6'b000110; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(12, g);
      checks++;
      if (g !== exp_g[i]) begin
        failures++;
        $display("FAIL b2b_order[%0d]: gnt=%b, required %b", i, g, exp_g[i]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    req = 6'b001000; out_ready = 1'b0;
    tick();                                   // SETUP
    req = '0;
    tick();                                   // XFER
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || sel !== 3'b100 || lane_mask !== 16'h0001 || out_last !== 1'b1 || gnt !== 6'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b sel=%b mask=%h last=%b gnt=%b, required 1 100 0001 1 000000",
                 c, out_valid, sel, lane_mask, out_last, gnt);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 6'b001000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: gnt=%b valid=%b, required 001000 0", gnt, out_valid);
    end
    $display("txn: stall gnt=%b", gnt);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] g;
    do_reset();
    req = 6'b100000; out_ready = 1'b0;
    tick();
    tick();                                   // XFER beat0
    checks++;
    if (out_valid !== 1'b1 || sel !== 3'b110) begin
      failures++;
      $display("FAIL rmid_pre: valid=%b sel=%b, required 1 110", out_valid, sel);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, sel, count, out_valid, out_last, lane_mask, busy} !== '0) begin
      failures++;
      $display("FAIL rmid_async: gnt=%b sel=%b count=%0d valid=%b last=%b mask=%h busy=%b, required all zero",
               gnt, sel, count, out_valid, out_last, lane_mask, busy);
    end
    req = 6'b100001; out_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 6'b0) begin
      failures++;
      $display("FAIL rmid_no_gnt: gnt=%b, required 000000", gnt);
    end
    rst = 1'b1;
    tick();                                   // SETUP of the first post-reset grant
    checks++;
    if (sel !== 3'b001) begin
      failures++;
      $display("FAIL rmid_first_sel: sel=%b, required 001", sel);
    end
    req = '0;
    wait_gnt(6, g);
    checks++;
    if (g !== 6'b000001) begin
      failures++;
      $display("FAIL rmid_first_gnt: gnt=%b, required 000001", g);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_counter();
    test_ksort();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
